// File: rtl/instr_fetch_aligner_if.sv
// Bundle of the aligner's fetch-memory bus, instruction output stream and redirect inputs.
// master = aligner side, slave = memory/consumer/redirect side.
interface instr_fetch_aligner_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_compressed;

  modport master (
    input  flush, flush_pc, fetch_gnt, fetch_rvalid, fetch_rdata, instr_ready,
    output fetch_req, fetch_addr, instr_valid, instr, instr_pc, instr_compressed
  );

  modport slave (
    output flush, flush_pc, fetch_gnt, fetch_rvalid, fetch_rdata, instr_ready,
    input  fetch_req, fetch_addr, instr_valid, instr, instr_pc, instr_compressed
  );
endinterface

// File: rtl/instr_fetch_aligner.sv
// Word-aligned instruction fetcher with a 4-halfword queue that re-aligns the stream
// at 16-bit granularity and emits one whole (RVC or 32-bit) instruction per handshake.
module instr_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rstn,
  instr_fetch_aligner_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned HW   = 16;
  localparam int unsigned CNTW = 3;

  // Fetch-port state: idle, waiting on a live response, waiting on a stale one to drop
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  logic [1:0]          r_state, w_state_nxt;
  logic [3:0][HW-1:0]  r_q, w_q_nxt;
  logic [CNTW-1:0]     r_count, w_count_nxt, w_pops, w_pushes;
  logic [1:0]          w_base;
  logic [XLEN-1:0]     r_pc, r_fetch_pc;
  logic                r_skip_low;
  logic                w_head_c16, w_valid, w_accept, w_push, w_fetch_req, w_compressed;

  assign w_head_c16   = (r_q[0][1:0] != 2'b11);
  assign w_valid      = ((r_count != '0) && w_head_c16) || (r_count >= CNTW'(2));
  assign w_compressed = (r_count != '0) && w_head_c16;
  assign w_accept     = w_valid && bus.instr_ready && !bus.flush;
  assign w_push       = (r_state == S_WAIT) && bus.fetch_rvalid && !bus.flush;
  // Issue only while the queue can absorb a full word even without any pops
  assign w_fetch_req  = rstn && (r_state == S_IDLE) && !bus.flush && (r_count <= CNTW'(2));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fetch_req && bus.fetch_gnt) w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.fetch_rvalid)              w_state_nxt = S_IDLE;
               else if (bus.flush)              w_state_nxt = S_DROP;
      S_DROP:  if (bus.fetch_rvalid)              w_state_nxt = S_IDLE;
      default:                                  w_state_nxt = S_IDLE;
    endcase
  end

  // Queue update: shift out popped halfwords, then append pushed ones after the survivors
  always_comb begin
    w_pops   = w_accept ? (w_head_c16 ? CNTW'(1) : CNTW'(2)) : '0;
    w_pushes = w_push ? (r_skip_low ? CNTW'(1) : CNTW'(2)) : '0;
    w_base   = 2'(r_count - w_pops);
    w_q_nxt  = r_q;
    if (w_pops == CNTW'(1))      w_q_nxt = {r_q[3], r_q[3], r_q[2], r_q[1]};
    else if (w_pops == CNTW'(2)) w_q_nxt = {r_q[3], r_q[2], r_q[3], r_q[2]};
    if (w_push) begin
      if (r_skip_low) begin
        w_q_nxt[w_base] = bus.fetch_rdata[31:16];
      end else begin
        w_q_nxt[w_base]        = bus.fetch_rdata[15:0];
        w_q_nxt[w_base + 2'd1] = bus.fetch_rdata[31:16];
      end
    end
    w_count_nxt = r_count - w_pops + w_pushes;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_q        <= '0;
      r_count    <= '0;
      r_pc       <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_skip_low <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.flush) begin
        r_count    <= '0;
        r_pc       <= bus.flush_pc & ~XLEN'(1);
        r_fetch_pc <= {bus.flush_pc[XLEN-1:2], 2'b00};
        r_skip_low <= bus.flush_pc[1];
      end else begin
        r_q     <= w_q_nxt;
        r_count <= w_count_nxt;
        if (w_accept)                     r_pc       <= r_pc + (w_head_c16 ? XLEN'(2) : XLEN'(4));
        if (w_fetch_req && bus.fetch_gnt) r_fetch_pc <= r_fetch_pc + XLEN'(4);
        if (w_push)                       r_skip_low <= 1'b0;
      end
    end
  end

  assign bus.fetch_req        = w_fetch_req;
  assign bus.fetch_addr       = r_fetch_pc;
  assign bus.instr_valid      = w_valid;
  assign bus.instr_compressed = w_compressed;
  assign bus.instr            = w_compressed ? {16'h0000, r_q[0]} : {r_q[1], r_q[0]};
  assign bus.instr_pc         = r_pc;

endmodule

// File: tb/tb_instr_fetch_aligner.sv
// Directed bench for instr_fetch_aligner: memory responder with programmable latency,
// linear stimulus with hand-computed expected instruction/PC sequences.
module tb_instr_fetch_aligner;
  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        tb_flush    = 1'b0;
  logic [31:0] tb_flush_pc = 32'h0;
  logic        tb_ready    = 1'b0;
  logic        tb_gnt_en   = 1'b0;
  logic        tb_rvalid   = 1'b0;
  logic [31:0] tb_rdata    = 32'h0;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [31:0]];
  int          rsp_delay = 0;
  logic        rsp_have  = 1'b0;
  logic [31:0] rsp_addr  = 32'h0;
  int          rsp_cnt   = 0;

  instr_fetch_aligner_if bus ();

  assign bus.flush       = tb_flush;
  assign bus.flush_pc    = tb_flush_pc;
  assign bus.instr_ready = tb_ready;
  assign bus.fetch_gnt   = bus.fetch_req & tb_gnt_en;
  assign bus.fetch_rvalid = tb_rvalid;
  assign bus.fetch_rdata  = tb_rdata;

  instr_fetch_aligner #(.RESET_PC(32'h0000_0100)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0013;
  endfunction

  // Instruction memory: one response rsp_delay cycles after the cycle following a grant
  always @(posedge clk) begin
    logic        g;
    logic [31:0] a;
    g = bus.fetch_req && bus.fetch_gnt;
    a = bus.fetch_addr;
    #1;
    tb_rvalid = 1'b0;
    if (!rstn) begin
      rsp_have = 1'b0;
    end else begin
      if (g) begin
        rsp_have = 1'b1;
        rsp_addr = a;
        rsp_cnt  = rsp_delay;
      end
      if (rsp_have) begin
        if (rsp_cnt == 0) begin
          tb_rvalid = 1'b1;
          tb_rdata  = mem_rd(rsp_addr);
          rsp_have  = 1'b0;
        end else begin
          rsp_cnt = rsp_cnt - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_req"},   32'(bus.fetch_req), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'h0);
    check({tag, "_pc"},    bus.instr_pc, 32'h100);
    check({tag, "_comp"},  32'(bus.instr_compressed), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rstn     = 1'b0;
    tb_flush = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs(tag);
    rstn = 1'b1;
  endtask

  // Waits (bounded) for a valid instruction, checks it, and lets it be consumed
  task automatic wait_out(input string tag, input logic [31:0] e_instr,
                          input logic [31:0] e_pc, input logic e_c);
    int n;
    n = 0;
    #1;
    while (bus.instr_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check({tag, "_instr"}, bus.instr, e_instr);
    check({tag, "_pc"},    bus.instr_pc, e_pc);
    check({tag, "_comp"},  32'(bus.instr_compressed), 32'(e_c));
    @(negedge clk);
  endtask

  initial begin
    int n;
    tb_gnt_en = 1'b1;

    // 1: single 32-bit nop
    mem.delete();
    mem[32'h100] = 32'h0000_0013;
    tb_ready = 1'b1;
    do_reset("t1_rst");
    #1;
    check("t1_req",  32'(bus.fetch_req), 32'd1);
    check("t1_addr", bus.fetch_addr, 32'h100);
    wait_out("t1_o0", 32'h0000_0013, 32'h100, 1'b0);

    // 2: two compressed instructions in one word
    mem.delete();
    mem[32'h100] = 32'h4501_4501;
    do_reset("t2_rst");
    wait_out("t2_o0", 32'h0000_4501, 32'h100, 1'b1);
    wait_out("t2_o1", 32'h0000_4501, 32'h102, 1'b1);

    // 3: 32-bit instruction straddling a word boundary
    mem.delete();
    mem[32'h100] = 32'h0013_4501;
    mem[32'h104] = 32'h4501_0000;
    do_reset("t3_rst");
    wait_out("t3_o0", 32'h0000_4501, 32'h100, 1'b1);
    #1;
    check("t3_straddle_wait", 32'(bus.instr_valid), 32'd0);
    wait_out("t3_o1", 32'h0000_0013, 32'h102, 1'b0);
    wait_out("t3_o2", 32'h0000_4501, 32'h106, 1'b1);

    // 4: backpressure on a nop stream
    mem.delete();
    tb_ready = 1'b0;
    do_reset("t4_rst");
    n = 0;
    #1;
    while (bus.instr_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 8; i++) begin
      check("t4_hold_valid", 32'(bus.instr_valid), 32'd1);
      check("t4_hold_instr", bus.instr, 32'h0000_0013);
      check("t4_hold_pc",    bus.instr_pc, 32'h100);
      @(negedge clk);
      #1;
    end
    check("t4_full_req",   32'(bus.fetch_req), 32'd0);
    check("t4_full_count", 32'(dut.r_count), 32'd4);
    tb_ready = 1'b1;
    wait_out("t4_o0", 32'h0000_0013, 32'h100, 1'b0);
    wait_out("t4_o1", 32'h0000_0013, 32'h104, 1'b0);
    wait_out("t4_o2", 32'h0000_0013, 32'h108, 1'b0);
    wait_out("t4_o3", 32'h0000_0013, 32'h10c, 1'b0);

    // 5: flush to a halfword address while a slow fetch is outstanding
    mem.delete();
    mem[32'h200] = 32'h4501_0013;
    rsp_delay = 3;
    do_reset("t5_rst");
    @(negedge clk);
    #1;
    check("t5_pending_req", 32'(bus.fetch_req), 32'd0);
    tb_flush    = 1'b1;
    tb_flush_pc = 32'h202;
    @(negedge clk);
    tb_flush = 1'b0;
    #1;
    check("t5_post_valid", 32'(bus.instr_valid), 32'd0);
    check("t5_post_req",   32'(bus.fetch_req), 32'd0);
    check("t5_post_pc",    bus.instr_pc, 32'h202);
    n = 0;
    while (bus.fetch_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t5_refetch_req",  32'(bus.fetch_req), 32'd1);
    check("t5_refetch_addr", bus.fetch_addr, 32'h200);
    wait_out("t5_o0", 32'h0000_4501, 32'h202, 1'b1);
    wait_out("t5_o1", 32'h0000_0013, 32'h204, 1'b0);
    rsp_delay = 0;

    // 6: flush coinciding with an accept and a read response, then async reset pulse
    mem.delete();
    mem[32'h100] = 32'h4501_4501;
    mem[32'h104] = 32'h4501_4501;
    mem[32'h300] = 32'h0000_0013;
    do_reset("t6_rst");
    wait_out("t6_o0", 32'h0000_4501, 32'h100, 1'b1);
    #1;
    check("t6_pre_valid", 32'(bus.instr_valid), 32'd1);
    check("t6_pre_pc",    bus.instr_pc, 32'h102);
    tb_flush    = 1'b1;
    tb_flush_pc = 32'h301;
    @(negedge clk);
    tb_flush = 1'b0;
    #1;
    check("t6_post_valid", 32'(bus.instr_valid), 32'd0);
    check("t6_post_pc",    bus.instr_pc, 32'h300);
    check("t6_post_req",   32'(bus.fetch_req), 32'd1);
    check("t6_post_addr",  bus.fetch_addr, 32'h300);
    wait_out("t6_o1", 32'h0000_0013, 32'h300, 1'b0);
    @(negedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_out("t6_o2", 32'h0000_4501, 32'h100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
